// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, extracts load data, hands off to WB.
// Optional MEM_LOAD_BYPASS_EN lets ID forward load data in the cycle the response arrives.
module mem_stage #(
  parameter int EXE_TO_MEM_WD = 75,
  parameter int MEM_TO_WB_WD  = 70,
  parameter int MEM_TO_ID_WD  = 40
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     mem_allowin,
  input  logic                     exe_to_mem_valid,
  input  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
  input  logic                     wb_allowin,
  output logic                     mem_to_wb_valid,
  output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus,
  input  logic                     data_sram_data_ok,
  input  logic [31:0]              data_sram_rdata
);

  logic                     mem_valid_reg;
  logic [EXE_TO_MEM_WD-1:0] mem_data_reg;
  logic                     buf_valid_reg;
  logic [31:0]              buf_rdata_reg;

  logic        regw;
  logic [4:0]  waddr;
  logic [31:0] res;
  logic        is_ld;
  logic [2:0]  ld_op;
  logic        need_data;
  logic [31:0] pc;

  assign {regw, waddr, res, is_ld, ld_op, need_data, pc} = mem_data_reg;

  logic mem_ready_go;
  logic mem_leave;
  logic buf_capture;

  assign mem_ready_go    = ~need_data | data_sram_data_ok | buf_valid_reg;
  assign mem_allowin     = ~mem_valid_reg | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid_reg & mem_ready_go;
  assign mem_leave       = mem_to_wb_valid & wb_allowin;
  // A response that arrives while WB is stalled must be held; the SRAM will not repeat it.
  assign buf_capture     = mem_valid_reg & need_data & data_sram_data_ok
                         & ~wb_allowin & ~buf_valid_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_reg <= 1'b0;
      buf_valid_reg <= 1'b0;
    end else begin
      if (mem_allowin) begin
        mem_valid_reg <= exe_to_mem_valid;
      end
      if (mem_leave) begin
        buf_valid_reg <= 1'b0;
      end else if (buf_capture) begin
        buf_valid_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_allowin && exe_to_mem_valid) begin
      mem_data_reg <= exe_to_mem_bus;
    end
    if (buf_capture) begin
      buf_rdata_reg <= data_sram_rdata;
    end
  end

  logic [31:0] raw_rdata;
  logic [7:0]  rd_byte [4];
  logic [15:0] rd_half [2];

  assign raw_rdata = buf_valid_reg ? buf_rdata_reg : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign rd_byte[gi] = raw_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign rd_half[gi] = raw_rdata[16*gi +: 16];
    end
  endgenerate

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ld_data;
  logic [31:0] wdata;

  assign sel_byte = rd_byte[res[1:0]];
  assign sel_half = rd_half[res[1]];

  always_comb begin
    ld_data = raw_rdata;
    case (ld_op)
      3'b001:  ld_data = {{24{sel_byte[7]}}, sel_byte};
      3'b010:  ld_data = {{16{sel_half[15]}}, sel_half};
      3'b011:  ld_data = {24'd0, sel_byte};
      3'b100:  ld_data = {16'd0, sel_half};
      default: ld_data = raw_rdata;
    endcase
  end

  assign wdata = is_ld ? ld_data : res;

  assign mem_to_wb_bus = {regw, waddr, wdata, pc};

  logic fwd_we;
  logic [4:0] fwd_addr;
  logic fwd_rdy;

  assign fwd_we   = regw & mem_valid_reg;
  assign fwd_addr = mem_valid_reg ? waddr : 5'd0;
`ifdef MEM_LOAD_BYPASS_EN
  assign fwd_rdy  = ~is_ld | data_sram_data_ok | buf_valid_reg;
`else
  assign fwd_rdy  = ~is_ld;
`endif

  assign mem_to_id_bus = {mem_valid_reg, fwd_we, fwd_addr, wdata, fwd_rdy};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// checked against a behavioural load/response model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        mem_allowin;
  logic        exe_to_mem_valid;
  logic [74:0] exe_to_mem_bus;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [39:0] mem_to_id_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int total;
  int bad;

`ifdef MEM_LOAD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_allowin       (mem_allowin),
    .exe_to_mem_valid  (exe_to_mem_valid),
    .exe_to_mem_bus    (exe_to_mem_bus),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id_bus     (mem_to_id_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire        o_regw     = mem_to_wb_bus[69];
  wire [4:0]  o_waddr    = mem_to_wb_bus[68:64];
  wire [31:0] o_wdata    = mem_to_wb_bus[63:32];
  wire [31:0] o_pc       = mem_to_wb_bus[31:0];
  wire        o_id_valid = mem_to_id_bus[39];
  wire        o_fwd_we   = mem_to_id_bus[38];
  wire [4:0]  o_fwd_addr = mem_to_id_bus[37:33];
  wire [31:0] o_fwd_data = mem_to_id_bus[32:1];
  wire        o_fwd_rdy  = mem_to_id_bus[0];

  function automatic logic [74:0] mk_bus(input logic regw, input logic [4:0] waddr,
                                         input logic [31:0] res, input logic is_ld,
                                         input logic [2:0] op, input logic need,
                                         input logic [31:0] pc);
    return {regw, waddr, res, is_ld, op, need, pc};
  endfunction

  // Reference load result from the address offset and raw word, by shifting and masking.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * addr[1:0])) & 32'hFF;
    h = (raw >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus = '0;
    wb_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    step();
    step();
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", mem_to_wb_valid); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b exp=1", mem_allowin); end
    total++; if (o_fwd_we !== 1'b0) begin bad++; $display("FAIL reset_fwd_we got=%b exp=0", o_fwd_we); end
    total++; if (o_fwd_addr !== 5'd0) begin bad++; $display("FAIL reset_fwd_addr got=%0d exp=0", o_fwd_addr); end
    total++; if (o_id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", o_id_valid); end
    resetn = 1'b1;
    step();
    $display("reset: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_alu();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus = mk_bus(1'b1, 5'd5, 32'h12345678, 1'b0, 3'd0, 1'b0, 32'h1C000010);
    wb_allowin = 1'b1;
    sample();
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL alu_allowin got=%b exp=1", mem_allowin); end
    step();
    exe_to_mem_valid = 1'b0;
    sample();
    total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", mem_to_wb_valid); end
    total++; if (o_wdata !== 32'h12345678) begin bad++; $display("FAIL alu_wdata got=%h exp=12345678", o_wdata); end
    total++; if (o_waddr !== 5'd5) begin bad++; $display("FAIL alu_waddr got=%0d exp=5", o_waddr); end
    total++; if (o_pc !== 32'h1C000010) begin bad++; $display("FAIL alu_pc got=%h exp=1c000010", o_pc); end
    total++; if (o_fwd_we !== 1'b1) begin bad++; $display("FAIL alu_fwd_we got=%b exp=1", o_fwd_we); end
    total++; if (o_fwd_rdy !== 1'b1) begin bad++; $display("FAIL alu_fwd_rdy got=%b exp=1", o_fwd_rdy); end
    total++; if (o_fwd_data !== 32'h12345678) begin bad++; $display("FAIL alu_fwd_data got=%h exp=12345678", o_fwd_data); end
    step();
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL alu_drained got=%b exp=0", mem_to_wb_valid); end
    $display("alu: wdata=%h total=%0d bad=%0d", o_wdata, total, bad);
  endtask

  task automatic test_ld_b();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus = mk_bus(1'b1, 5'd9, 32'h00001003, 1'b1, 3'd1, 1'b1, 32'h1C000020);
    step();
    exe_to_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL ldb_wait_valid cyc=%0d got=%b exp=0", i, mem_to_wb_valid); end
      total++; if (mem_allowin !== 1'b0) begin bad++; $display("FAIL ldb_wait_allowin cyc=%0d got=%b exp=0", i, mem_allowin); end
      total++; if (o_fwd_rdy !== 1'b0) begin bad++; $display("FAIL ldb_wait_fwd_rdy cyc=%0d got=%b exp=0", i, o_fwd_rdy); end
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF00AA;
    sample();
    total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL ldb_valid got=%b exp=1", mem_to_wb_valid); end
    total++; if (o_wdata !== 32'hFFFFFF80) begin bad++; $display("FAIL ldb_wdata got=%h exp=ffffff80", o_wdata); end
    total++; if (o_fwd_rdy !== BYPASS) begin bad++; $display("FAIL ldb_fwd_rdy got=%b exp=%b", o_fwd_rdy, BYPASS); end
    step();
    data_sram_data_ok = 1'b0;
    $display("ld_b: wdata=%h total=%0d bad=%0d", o_wdata, total, bad);
  endtask

  task automatic test_ld_half();
    logic [2:0]  ops  [2];
    logic [31:0] exps [2];
    ops[0] = 3'd4; exps[0] = 32'h0000BEEF;
    ops[1] = 3'd2; exps[1] = 32'hFFFFBEEF;
    for (int k = 0; k < 2; k++) begin
      exe_to_mem_valid = 1'b1;
      exe_to_mem_bus = mk_bus(1'b1, 5'd11, 32'h00001002, 1'b1, ops[k], 1'b1, 32'h1C000030);
      step();
      exe_to_mem_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hBEEF0000;
      sample();
      total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL ldh_valid op=%0d got=%b exp=1", ops[k], mem_to_wb_valid); end
      total++; if (o_wdata !== exps[k]) begin bad++; $display("FAIL ldh_wdata op=%0d got=%h exp=%h", ops[k], o_wdata, exps[k]); end
      step();
      data_sram_data_ok = 1'b0;
      $display("ld_half: op=%0d wdata=%h", ops[k], o_wdata);
    end
  endtask

  task automatic test_stall_buffer();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus = mk_bus(1'b1, 5'd7, 32'h00002000, 1'b1, 3'd0, 1'b1, 32'h1C000040);
    step();
    exe_to_mem_valid = 1'b0;
    wb_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFEF00D;
    sample();
    total++; if (mem_allowin !== 1'b0) begin bad++; $display("FAIL buf_allowin_stalled got=%b exp=0", mem_allowin); end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h00000000;
    sample();
    total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL buf_held_valid got=%b exp=1", mem_to_wb_valid); end
    total++; if (o_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL buf_held_wdata got=%h exp=cafef00d", o_wdata); end
    total++; if (o_fwd_rdy !== BYPASS) begin bad++; $display("FAIL buf_fwd_rdy got=%b exp=%b", o_fwd_rdy, BYPASS); end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h11111111;
    sample();
    total++; if (o_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL buf_stray_wdata got=%h exp=cafef00d", o_wdata); end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h22222222;
    wb_allowin = 1'b1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus = mk_bus(1'b1, 5'd8, 32'h00002004, 1'b1, 3'd0, 1'b1, 32'h1C000044);
    sample();
    total++; if (o_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL buf_release_wdata got=%h exp=cafef00d", o_wdata); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL buf_release_allowin got=%b exp=1", mem_allowin); end
    step();
    exe_to_mem_valid = 1'b0;
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL buf_cleared_valid got=%b exp=0", mem_to_wb_valid); end
    total++; if (o_waddr !== 5'd8) begin bad++; $display("FAIL buf_next_waddr got=%0d exp=8", o_waddr); end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BADF00D;
    sample();
    total++; if (o_wdata !== 32'h0BADF00D) begin bad++; $display("FAIL buf_next_wdata got=%h exp=0badf00d", o_wdata); end
    step();
    data_sram_data_ok = 1'b0;
    $display("stall_buffer: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_store();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus = mk_bus(1'b0, 5'd3, 32'h00003000, 1'b0, 3'd0, 1'b1, 32'h1C000050);
    step();
    exe_to_mem_valid = 1'b0;
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL st_wait_valid got=%b exp=0", mem_to_wb_valid); end
    step();
    data_sram_data_ok = 1'b1;
    sample();
    total++; if (mem_to_wb_valid !== 1'b1) begin bad++; $display("FAIL st_valid got=%b exp=1", mem_to_wb_valid); end
    total++; if (o_fwd_we !== 1'b0) begin bad++; $display("FAIL st_fwd_we got=%b exp=0", o_fwd_we); end
    step();
    wb_allowin = 1'b0;
    data_sram_rdata = 32'hDEADBEEF;
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL stray_valid got=%b exp=0", mem_to_wb_valid); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL stray_allowin got=%b exp=1", mem_allowin); end
    step();
    data_sram_data_ok = 1'b0;
    wb_allowin = 1'b1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus = mk_bus(1'b1, 5'd4, 32'h00003004, 1'b1, 3'd0, 1'b1, 32'h1C000054);
    step();
    exe_to_mem_valid = 1'b0;
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL stray_no_buffer got=%b exp=0", mem_to_wb_valid); end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h13579BDF;
    step();
    data_sram_data_ok = 1'b0;
    $display("store: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_mid_wait();
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus = mk_bus(1'b1, 5'd12, 32'h00004000, 1'b1, 3'd0, 1'b1, 32'h1C000060);
    step();
    exe_to_mem_valid = 1'b0;
    step();
    resetn = 1'b0;
    step();
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL rstw_valid got=%b exp=0", mem_to_wb_valid); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL rstw_allowin got=%b exp=1", mem_allowin); end
    total++; if (o_fwd_addr !== 5'd0) begin bad++; $display("FAIL rstw_fwd_addr got=%0d exp=0", o_fwd_addr); end
    resetn = 1'b1;
    // Reset while a response is buffered must also drop the buffer.
    exe_to_mem_valid = 1'b1;
    step();
    exe_to_mem_valid = 1'b0;
    wb_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h55AA55AA;
    step();
    data_sram_data_ok = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    wb_allowin = 1'b1;
    exe_to_mem_valid = 1'b1;
    step();
    exe_to_mem_valid = 1'b0;
    sample();
    total++; if (mem_to_wb_valid !== 1'b0) begin bad++; $display("FAIL rstb_no_buffer got=%b exp=0", mem_to_wb_valid); end
    step();
    data_sram_data_ok = 1'b1;
    step();
    data_sram_data_ok = 1'b0;
    $display("reset_mid_wait: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random();
    logic        regw, is_ld, need, got, dok, stray, ready, done;
    logic [4:0]  waddr;
    logic [2:0]  op;
    logic [31:0] res, pc, resp, exp_wdata;
    logic        exp_rdy;
    int          kind, delay;
    for (int n = 0; n < 60; n++) begin
      kind  = $urandom_range(0, 2);
      waddr = 5'($urandom);
      res   = $urandom;
      pc    = $urandom;
      op    = 3'($urandom);
      is_ld = (kind == 1);
      need  = (kind != 0);
      regw  = (kind == 2) ? 1'b0 : 1'b1;
      resp  = $urandom;
      delay = $urandom_range(0, 3);
      exp_wdata = is_ld ? ref_load(op, res, resp) : res;
      exe_to_mem_valid = 1'b1;
      exe_to_mem_bus = mk_bus(regw, waddr, res, is_ld, op, need, pc);
      wb_allowin = 1'($urandom);
      data_sram_data_ok = 1'b0;
      sample();
      total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL rnd_accept n=%0d got=%b exp=1", n, mem_allowin); end
      step();
      exe_to_mem_valid = 1'b0;
      got  = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        dok   = need && !got && (c == delay);
        stray = got && 1'($urandom);
        data_sram_data_ok = dok | stray;
        data_sram_rdata   = dok ? resp : $urandom;
        wb_allowin = (c >= 6) ? 1'b1 : 1'($urandom);
        ready   = !need || dok || got;
        exp_rdy = !is_ld || (BYPASS && (dok || got));
        sample();
        total++; if (mem_to_wb_valid !== ready) begin bad++; $display("FAIL rnd_valid n=%0d c=%0d got=%b exp=%b", n, c, mem_to_wb_valid, ready); end
        total++; if (mem_allowin !== (ready && wb_allowin)) begin bad++; $display("FAIL rnd_allowin n=%0d c=%0d got=%b exp=%b", n, c, mem_allowin, ready && wb_allowin); end
        total++; if (o_fwd_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_fwd_rdy n=%0d c=%0d got=%b exp=%b", n, c, o_fwd_rdy, exp_rdy); end
        total++; if (o_fwd_we !== regw) begin bad++; $display("FAIL rnd_fwd_we n=%0d got=%b exp=%b", n, o_fwd_we, regw); end
        total++; if (o_fwd_addr !== waddr) begin bad++; $display("FAIL rnd_fwd_addr n=%0d got=%0d exp=%0d", n, o_fwd_addr, waddr); end
        if (ready) begin
          total++; if (o_wdata !== exp_wdata) begin bad++; $display("FAIL rnd_wdata n=%0d op=%0d res=%h got=%h exp=%h", n, op, res, o_wdata, exp_wdata); end
          total++; if ({o_regw, o_waddr, o_pc} !== {regw, waddr, pc}) begin bad++; $display("FAIL rnd_hdr n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, o_regw, o_waddr, o_pc, regw, waddr, pc); end
        end
        step();
        if (ready && wb_allowin) done = 1'b1;
        else if (dok) got = 1'b1;
      end
      total++; if (!done) begin bad++; $display("FAIL rnd_timeout n=%0d got=0 exp=1", n); end
      data_sram_data_ok = 1'b0;
      $display("random: n=%0d kind=%0d op=%0d wdata=%h", n, kind, op, exp_wdata);
    end
    wb_allowin = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_alu();
    test_ld_b();
    test_ld_half();
    test_stall_buffer();
    test_store();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
